tiny_npu_vmu: RTL

Parametrised weight-stationary vector-matrix unit, successor to the fixed 4-lane TinyNPU datapath. It holds a ROWS×COLS signed weight matrix and a ROWS-entry input vector, then computes z[c] = sat(act((Σr x[r]·W[r][c]) >>> DBITS)) for every column. It adds three things the previous generation lacked: independent row and column counts, a ReLU mode, and saturating fixed-point output. Results stream out over a valid/ready handshake, one column per beat.

---
 rtl/tiny_npu_vmu.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/tiny_npu_vmu.sv
// Weight-stationary vector-matrix unit: z[c] = sat(act((sum_r x[r]*W[r][c]) >>> DBITS)),
// one row accumulated per cycle, results streamed one column per valid/ready beat.
module tiny_npu_vmu #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int NBITS = 8,
  parameter int DBITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NBITS-1:0]        x_in,
  input  logic                    x_load_val,
  input  logic [NBITS-1:0]        w_in,
  input  logic                    w_load_val,
  input  logic [$clog2(ROWS)-1:0] w_load_row,
  input  logic [$clog2(COLS)-1:0] w_load_col,
  input  logic                    relu_en,
  input  logic                    start,
  output logic                    busy,
  output logic                    x_full,
  output logic [NBITS-1:0]        z_out,
  output logic                    z_val,
  input  logic                    z_rdy,
  output logic [3:0]              trace_state
);
  localparam int ACC_BITS = 2*NBITS + $clog2(ROWS);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(ROWS+1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS-1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS-1);
  localparam logic [PW-1:0] FULL_CNT = PW'(ROWS);
  localparam logic signed [ACC_BITS-1:0] SAT_MAX = ACC_BITS'((64'sd1 <<< (NBITS-1)) - 64'sd1);
  localparam logic signed [ACC_BITS-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MAC = 2'd1, S_OUT = 2'd2} state_t;
  state_t r_state, w_next;

  logic signed [NBITS-1:0]    r_w   [ROWS][COLS];
  logic signed [NBITS-1:0]    r_x   [ROWS];
  logic signed [ACC_BITS-1:0] r_acc [COLS];
  logic signed [2*NBITS-1:0]  w_prod [COLS];
  logic [PW-1:0] r_x_ptr;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          r_relu;
  logic          w_x_full, w_start_ok, w_beat, w_last_beat;

  // Arithmetic shift floors toward -inf; ReLU and clamp then fold the result into NBITS.
  function automatic logic [NBITS-1:0] act_sat(input logic signed [ACC_BITS-1:0] acc,
                                               input logic relu);
    logic signed [ACC_BITS-1:0] s;
    s = acc >>> DBITS;
    if (relu && s[ACC_BITS-1])  act_sat = '0;
    else if (s > SAT_MAX)       act_sat = SAT_MAX[NBITS-1:0];
    else if (s < SAT_MIN)       act_sat = SAT_MIN[NBITS-1:0];
    else                        act_sat = s[NBITS-1:0];
  endfunction

  assign w_x_full    = (r_x_ptr == FULL_CNT);
  assign w_start_ok  = (r_state == S_IDLE) && start && w_x_full;
  assign w_beat      = (r_state == S_OUT) && z_rdy;
  assign w_last_beat = w_beat && (r_col == LAST_COL);

  assign x_full      = w_x_full;
  assign busy        = (r_state != S_IDLE);
  assign z_val       = (r_state == S_OUT);
  assign z_out       = act_sat(r_acc[r_col], r_relu);
  assign trace_state = {2'b00, r_state};

  // One signed product per column for the row currently being accumulated.
  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      w_prod[c] = r_x[r_row] * r_w[r_row][c];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_next = S_MAC;  else w_next = S_IDLE;
      S_MAC:   if (r_row == LAST_ROW) w_next = S_OUT; else w_next = S_MAC;
      S_OUT:   if (w_last_beat) w_next = S_IDLE; else w_next = S_OUT;
      default: w_next = S_IDLE;
    endcase
  end

  // Storage, accumulators and counters; loads only land while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        r_x[r] <= '0;
        for (int c = 0; c < COLS; c++) r_w[r][c] <= '0;
      end
      for (int c = 0; c < COLS; c++) r_acc[c] <= '0;
      r_x_ptr <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_relu  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_load_val) r_w[w_load_row][w_load_col] <= w_in;
          if (x_load_val && !w_x_full) begin
            r_x[r_x_ptr[RW-1:0]] <= x_in;
            r_x_ptr <= r_x_ptr + 1'b1;
          end
          if (w_start_ok) begin
            for (int c = 0; c < COLS; c++) r_acc[c] <= '0;
            r_relu <= relu_en;
            r_row  <= '0;
            r_col  <= '0;
          end
        end
        S_MAC: begin
          for (int c = 0; c < COLS; c++) begin
            r_acc[c] <= r_acc[c] + {{(ACC_BITS-2*NBITS){w_prod[c][2*NBITS-1]}}, w_prod[c]};
          end
          if (r_row == LAST_ROW) r_row <= '0;
          else                   r_row <= r_row + 1'b1;
        end
        S_OUT: begin
          if (w_last_beat) begin
            r_col   <= '0;
            r_x_ptr <= '0;
          end else if (w_beat) begin
            r_col <= r_col + 1'b1;
          end else begin
            r_col <= r_col;
          end
        end
        default: r_row <= '0;
      endcase
    end
  end

endmodule
